// File: rtl/text_console_ctrl.sv
// rtl/text_console_ctrl.sv - byte stream to text VRAM cell writes with cursor, control codes and clears.
// Optional scrolling is built when CONSOLE_SCROLL_EN is defined.
module text_console_ctrl #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 13
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [7:0]              data_i,
    output logic                    in_ready,
    output logic [$clog2(COLS)-1:0] cursor_x,
    output logic [$clog2(ROWS)-1:0] cursor_y,
    output logic [$clog2(ROWS)-1:0] row_base,
    output logic                    write,
    output logic [ADDR_W-1:0]       addr_vram,
    output logic [7:0]              character
);
    localparam int XW  = $clog2(COLS);
    localparam int YW  = $clog2(ROWS);
    localparam int YW1 = YW + 1;
    localparam logic [XW-1:0]     X_MAX    = XW'(COLS - 1);
    localparam logic [YW-1:0]     Y_MAX    = YW'(ROWS - 1);
    localparam logic [ADDR_W-1:0] CELL_MAX = ADDR_W'(COLS * ROWS - 1);
    localparam logic [7:0]        SPACE    = 8'h20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef CONSOLE_SCROLL_EN
        CLR_LINE = 2'd2,
`endif
        CLR_PAGE = 2'd1
    } state_e;

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [YW-1:0]     base_q, base_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        char_q, char_d;
    logic [ADDR_W-1:0] cell_q, cell_d;
    logic              done_q, done_d;
`ifdef CONSOLE_SCROLL_EN
    logic [XW-1:0]     col_q, col_d;
    logic [YW-1:0]     clr_row_q, clr_row_d;
`endif

    logic              is_print;
    logic              newline;
    logic [ADDR_W-1:0] cur_addr;

    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] base, input logic [YW-1:0] y);
        logic [YW:0] s;
        s = {1'b0, base} + {1'b0, y};
        if (s >= YW1'(ROWS)) s = s - YW1'(ROWS);
        return s[YW-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] row_start(input logic [YW-1:0] r);
        return ADDR_W'(r) * ADDR_W'(COLS);
    endfunction

    assign is_print = (data_i >= 8'h20) && (data_i != 8'h7F);
    assign cur_addr = row_start(phys_row(base_q, y_q)) + ADDR_W'(x_q);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        base_d    = base_q;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        char_d    = char_q;
        cell_d    = cell_q;
        done_d    = done_q;
        newline   = 1'b0;
`ifdef CONSOLE_SCROLL_EN
        col_d     = col_q;
        clr_row_d = clr_row_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_print) begin
                        wr_d   = 1'b1;
                        addr_d = cur_addr;
                        char_d = data_i;
                        if (x_q == X_MAX) begin
                            x_d     = '0;
                            newline = 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end else begin
                        case (data_i)
                            8'h0D: x_d = '0;
                            8'h0A: newline = 1'b1;
                            8'h0C: begin
                                state_d = CLR_PAGE;
                                base_d  = '0;
                                x_d     = '0;
                                y_d     = '0;
                                cell_d  = '0;
                                done_d  = 1'b0;
                            end
                            8'h08, 8'h7F: begin
                                // Backspace blanks the cell it lands on, wrapping to the previous row end.
                                if (x_q != '0) begin
                                    x_d    = x_q - 1'b1;
                                    wr_d   = 1'b1;
                                    addr_d = cur_addr - ADDR_W'(1);
                                    char_d = SPACE;
                                end else if (y_q != '0) begin
                                    x_d    = X_MAX;
                                    y_d    = y_q - 1'b1;
                                    wr_d   = 1'b1;
                                    addr_d = row_start(phys_row(base_q, y_q - 1'b1)) + ADDR_W'(X_MAX);
                                    char_d = SPACE;
                                end
                            end
                            8'h11: if (x_q != '0)    x_d = x_q - 1'b1;
                            8'h12: if (x_q != X_MAX) x_d = x_q + 1'b1;
                            8'h13: if (y_q != '0)    y_d = y_q - 1'b1;
                            8'h14: if (y_q != Y_MAX) y_d = y_q + 1'b1;
                            default: ;
                        endcase
                    end
                    if (newline) begin
                        if (y_q != Y_MAX) begin
                            y_d = y_q + 1'b1;
                        end else begin
`ifdef CONSOLE_SCROLL_EN
                            // The old top row becomes the new bottom row and is blanked.
                            base_d    = (base_q == Y_MAX) ? '0 : base_q + 1'b1;
                            x_d       = '0;
                            clr_row_d = base_q;
                            col_d     = '0;
                            done_d    = 1'b0;
                            state_d   = CLR_LINE;
`else
                            y_d = '0;
                            x_d = '0;
`endif
                        end
                    end
                end
            end
            CLR_PAGE: begin
                if (done_q) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = cell_q;
                    char_d = SPACE;
                    if (cell_q == CELL_MAX) done_d = 1'b1;
                    else                    cell_d = cell_q + 1'b1;
                end
            end
`ifdef CONSOLE_SCROLL_EN
            CLR_LINE: begin
                if (done_q) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = row_start(clr_row_q) + ADDR_W'(col_q);
                    char_d = SPACE;
                    if (col_q == X_MAX) done_d = 1'b1;
                    else                col_d  = col_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            char_q    <= '0;
            cell_q    <= '0;
            done_q    <= 1'b0;
`ifdef CONSOLE_SCROLL_EN
            col_q     <= '0;
            clr_row_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            char_q    <= char_d;
            cell_q    <= cell_d;
            done_q    <= done_d;
`ifdef CONSOLE_SCROLL_EN
            col_q     <= col_d;
            clr_row_q <= clr_row_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign cursor_x  = x_q;
    assign cursor_y  = y_q;
    assign row_base  = base_q;
    assign write     = wr_q;
    assign addr_vram = addr_q;
    assign character = char_q;
endmodule

// File: tb/tb_text_console_ctrl.sv
// tb/tb_text_console_ctrl.sv - self-checking bench for text_console_ctrl (vectors, corner sequences, random vs model).
module tb_text_console_ctrl;
    localparam int C  = 40;
    localparam int R  = 30;
    localparam int AW = 13;
    localparam int N  = C * R;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [7:0]    data_i;
    logic          in_ready;
    logic [5:0]    cursor_x;
    logic [4:0]    cursor_y;
    logic [4:0]    row_base;
    logic          write;
    logic [AW-1:0] addr_vram;
    logic [7:0]    character;

    always #5 clk = ~clk;

    text_console_ctrl #(.COLS(C), .ROWS(R), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .data_i(data_i), .in_ready(in_ready),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .row_base(row_base), .write(write),
        .addr_vram(addr_vram), .character(character)
    );

    int total = 0;
    int bad   = 0;
    int wtotal = 0;
    int last_addr = 0;
    int last_char = 0;
    int w0;
    byte unsigned shadow [N];
    byte unsigned mv [N];
    int mx, my, mb, mw;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn === 1'b1 && write === 1'b1) begin
            wtotal++;
            last_addr = int'(addr_vram);
            last_char = int'(character);
            total++;
            if (int'(addr_vram) < N) shadow[addr_vram] = character;
            else begin
                bad++;
                $display("FAIL addr_range: got %0d expected below %0d", addr_vram, N);
            end
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        in_valid = 1'b0;
        data_i   = 8'h00;
        rstn     = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        w0       = wtotal;
        in_valid = 1'b1;
        data_i   = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ready();
        @(negedge clk);
    endtask

    task automatic accept_only(input logic [7:0] b);
        w0       = wtotal;
        in_valid = 1'b1;
        data_i   = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int xy();
        return int'(cursor_x) * 100 + int'(cursor_y);
    endfunction

    // Reference model: cursor/page semantics on a flat VRAM image.
    function automatic int maddr(input int x, input int y);
        return ((mb + y) % R) * C + x;
    endfunction

    task automatic mput(input int a, input byte unsigned v);
        mv[a] = v;
        mw++;
    endtask

    task automatic model_nl();
        if (my < R - 1) my++;
        else begin
`ifdef CONSOLE_SCROLL_EN
            int old;
            old = mb;
            mb  = (mb + 1) % R;
            mx  = 0;
            for (int i = 0; i < C; i++) mput(old * C + i, 8'h20);
`else
            my = 0;
            mx = 0;
`endif
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b != 8'h7F) begin
            mput(maddr(mx, my), b);
            if (mx == C - 1) begin mx = 0; model_nl(); end
            else mx++;
        end else begin
            case (b)
                8'h0D: mx = 0;
                8'h0A: model_nl();
                8'h0C: begin
                    for (int i = 0; i < N; i++) mput(i, 8'h20);
                    mb = 0; mx = 0; my = 0;
                end
                8'h08, 8'h7F: begin
                    if (mx > 0) begin mx--; mput(maddr(mx, my), 8'h20); end
                    else if (my > 0) begin mx = C - 1; my--; mput(maddr(mx, my), 8'h20); end
                end
                8'h11: if (mx > 0) mx--;
                8'h12: if (mx < C - 1) mx++;
                8'h13: if (my > 0) my--;
                8'h14: if (my < R - 1) my++;
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if (r < 55) begin
            b = 8'($urandom_range(32, 255));
            if (b == 8'h7F) b = 8'h41;
        end
        else if (r < 70) b = 8'h0A;
        else if (r < 75) b = 8'h0D;
        else if (r < 83) b = (r % 2 == 0) ? 8'h08 : 8'h7F;
        else if (r < 95) b = 8'($urandom_range(17, 20));
        else if (r < 99) begin
            b = 8'($urandom_range(0, 31));
            if (b == 8'h0C) b = 8'h00;
        end
        else b = 8'h0C;
        return b;
    endfunction

    typedef struct {
        logic [7:0] b;
        int ex;
        int ey;
        int nw;
        int ea;
        int ec;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int errs;
        int n;
        int k;
        logic [7:0] b;

        vecs[0]  = '{8'h41, 1,  0, 1, 0,  8'h41};
        vecs[1]  = '{8'h0D, 0,  0, 0, -1, -1};
        vecs[2]  = '{8'h12, 1,  0, 0, -1, -1};
        vecs[3]  = '{8'h14, 1,  1, 0, -1, -1};
        vecs[4]  = '{8'h08, 0,  1, 1, 40, 8'h20};
        vecs[5]  = '{8'h08, 39, 0, 1, 39, 8'h20};
        vecs[6]  = '{8'h7F, 38, 0, 1, 38, 8'h20};
        vecs[7]  = '{8'h13, 38, 0, 0, -1, -1};
        vecs[8]  = '{8'h11, 37, 0, 0, -1, -1};
        vecs[9]  = '{8'h0A, 37, 1, 0, -1, -1};
        vecs[10] = '{8'h01, 37, 1, 0, -1, -1};
        vecs[11] = '{8'h80, 38, 1, 1, 77, 8'h80};
        vecs[12] = '{8'h0D, 0,  1, 0, -1, -1};
        vecs[13] = '{8'h7E, 1,  1, 1, 40, 8'h7E};

        do_reset();
        chk("reset_write", write, 0);
        chk("reset_addr", int'(addr_vram), 0);
        chk("reset_char", int'(character), 0);
        chk("reset_ready", in_ready, 1);
        chk("reset_xy", xy(), 0);
        chk("reset_base", int'(row_base), 0);

        // Held in_valid: up at top row, then left at column 0, one byte per cycle.
        w0       = wtotal;
        in_valid = 1'b1;
        data_i   = 8'h13;
        @(posedge clk);
        @(negedge clk);
        chk("hold_up_ready", in_ready, 1);
        chk("hold_up_xy", xy(), 0);
        data_i = 8'h11;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_left_ready", in_ready, 1);
        chk("hold_left_xy", xy(), 0);
        chk("hold_writes", wtotal - w0, 0);
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            send_byte(vecs[i].b);
            chk($sformatf("vec%0d_x", i), int'(cursor_x), vecs[i].ex);
            chk($sformatf("vec%0d_y", i), int'(cursor_y), vecs[i].ey);
            chk($sformatf("vec%0d_nwrites", i), wtotal - w0, vecs[i].nw);
            if (vecs[i].nw == 1) begin
                chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].ea);
                chk($sformatf("vec%0d_char", i), last_char, vecs[i].ec);
            end
        end

        // Row wrap and backspace across the row boundary.
        do_reset();
        for (int i = 0; i < 39; i++) send_byte(8'h61 + 8'(i % 26));
        send_byte(8'h5A);
        chk("wrap_addr", last_addr, 39);
        chk("wrap_char", last_char, 8'h5A);
        chk("wrap_xy", xy(), 1);
        send_byte(8'h7F);
        chk("bs_wrap_nw", wtotal - w0, 1);
        chk("bs_wrap_addr", last_addr, 39);
        chk("bs_wrap_char", last_char, 8'h20);
        chk("bs_wrap_xy", xy(), 3900);
        send_byte(8'h0D);
        send_byte(8'h7F);
        chk("bs_origin_nw", wtotal - w0, 0);
        chk("bs_origin_xy", xy(), 0);

        // Line feed on the bottom row.
        for (int i = 0; i < 3; i++) send_byte(8'h12);
        for (int i = 0; i < 29; i++) send_byte(8'h14);
        chk("pre_lf_xy", xy(), 329);
        accept_only(8'h0A);
`ifdef CONSOLE_SCROLL_EN
        chk("lf_first_cycle_ready", in_ready, 0);
        errs = 0;
        for (int i = 0; i < C; i++) begin
            @(negedge clk);
            if (!(write === 1'b1 && int'(addr_vram) == i && character == 8'h20 && in_ready === 1'b0)) errs++;
        end
        chk("lf_clear_seq_errs", errs, 0);
        @(negedge clk);
        chk("lf_ready_after", in_ready, 1);
        chk("lf_base", int'(row_base), 1);
        chk("lf_xy", xy(), 29);
        for (int i = 0; i < 39; i++) send_byte(8'h12);
        accept_only(8'h51);
        chk("pr_bottom_write", write, 1);
        chk("pr_bottom_addr", int'(addr_vram), 39);
        chk("pr_bottom_ready", in_ready, 0);
        errs = 0;
        for (int i = 0; i < C; i++) begin
            @(negedge clk);
            if (!(write === 1'b1 && int'(addr_vram) == C + i && character == 8'h20 && in_ready === 1'b0)) errs++;
        end
        chk("pr_clear_seq_errs", errs, 0);
        @(negedge clk);
        chk("pr_ready_after", in_ready, 1);
        chk("pr_base", int'(row_base), 2);
        chk("pr_xy", xy(), 29);
`else
        repeat (3) @(negedge clk);
        chk("lf_nowrap_writes", wtotal - w0, 0);
        chk("lf_nowrap_xy", xy(), 0);
        chk("lf_nowrap_base", int'(row_base), 0);
        chk("lf_nowrap_ready", in_ready, 1);
`endif

        // Full page clear timing.
        send_byte(8'h12);
        accept_only(8'h0C);
        chk("ff_first_write", write, 0);
        chk("ff_first_ready", in_ready, 0);
        errs = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (!(write === 1'b1 && int'(addr_vram) == i && character == 8'h20 && in_ready === 1'b0)) errs++;
        end
        chk("ff_clear_seq_errs", errs, 0);
        @(negedge clk);
        chk("ff_ready_after", in_ready, 1);
        chk("ff_write_after", write, 0);
        chk("ff_xy", xy(), 0);
        chk("ff_base", int'(row_base), 0);

        // Reset in the middle of a page clear.
        send_byte(8'h14);
        accept_only(8'h0C);
        n = 0;
        k = 0;
        while (n < 100 && k < 2000) begin
            @(negedge clk);
            k++;
            if (write === 1'b1) n++;
        end
        chk("abort_reached_100", n, 100);
        rstn = 1'b0;
        #1;
        chk("abort_write", write, 0);
        chk("abort_addr", int'(addr_vram), 0);
        chk("abort_char", int'(character), 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_xy", xy(), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_byte(8'h42);
        chk("abort_b_nw", wtotal - w0, 1);
        chk("abort_b_addr", last_addr, 0);
        chk("abort_b_char", last_char, 8'h42);
        chk("abort_b_xy", xy(), 100);

        // Random stream against the reference model.
        do_reset();
        mx = 0; my = 0; mb = 0; mw = 0;
        model_byte(8'h0C);
        send_byte(8'h0C);
        for (int i = 0; i < 400; i++) begin
            b  = rnd_byte();
            mw = 0;
            model_byte(b);
            send_byte(b);
            chk($sformatf("rnd%0d_b%02h_xyb", i, b), xy() * 100 + int'(row_base), (mx * 100 + my) * 100 + mb);
            chk($sformatf("rnd%0d_b%02h_nw", i, b), wtotal - w0, mw);
        end
        errs = 0;
        for (int i = 0; i < N; i++) if (shadow[i] != mv[i]) errs++;
        chk("rnd_vram_mismatch_cells", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
